// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined multi-mode barrel shifter (LSL, LSR, ASR, ROR).
// There is one registered stage per shift-amount bit. Stage k shifts by 2^k when
// amt[k] is set. Every stage has valid/ready flow control, and a stall holds all
// loaded stages.
//
// Optional feature: define BARREL_SHIFTER_STICKY_EN to build sticky flops. The
// sticky flag is the OR of the bits each stage discards. It is 0 for ROR. When
// the macro is not defined, out_sticky is tied to 0.
//
// Ports:
//   clk, rst_n             rising-edge clock, async active-low reset
//   in_valid/in_ready      input handshake (in_ready is combinational)
//   in_data/in_amt/in_mode operand, shift amount, mode (00 LSL 01 LSR 10 ASR 11 ROR)
//   out_valid/out_ready    output handshake
//   out_data/out_sticky    registered result and sticky flag
module barrel_shifter_pipe #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky
);

  localparam int unsigned LAST     = AMT_W - 1;
  localparam logic [1:0]  MODE_LSL = 2'b00;
  localparam logic [1:0]  MODE_LSR = 2'b01;
  localparam logic [1:0]  MODE_ASR = 2'b10;
  localparam logic [1:0]  MODE_ROR = 2'b11;

  logic [AMT_W-1:0] v_q;
  logic [AMT_W-1:0] vin;
  logic [AMT_W-1:0] en;
  logic [WIDTH-1:0] data_q [AMT_W];
  logic [AMT_W-1:0] amt_q  [AMT_W];
  logic [1:0]       mode_q [AMT_W];
  logic             sign_q [AMT_W];

  // Shift the operand by sh positions in the given mode. ASR fills with the
  // sign bit that was captured at entry.
  function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       mode,
                                                  input logic             sign,
                                                  input int unsigned      sh);
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> sh) : '0;
    case (mode)
      MODE_LSL: shift_data = d << sh;
      MODE_LSR: shift_data = d >> sh;
      MODE_ASR: shift_data = (d >> sh) | fill;
      MODE_ROR: shift_data = (d >> sh) | (d << (WIDTH - sh));
      default:  shift_data = d;
    endcase
  endfunction

`ifdef BARREL_SHIFTER_STICKY_EN
  logic sticky_q [AMT_W];

  // Return the OR of the bits that a shift of sh positions pushes off the end.
  function automatic logic shift_disc(input logic [WIDTH-1:0] d,
                                      input logic [1:0]       mode,
                                      input int unsigned      sh);
    case (mode)
      MODE_LSL: shift_disc = |(d & ~({WIDTH{1'b1}} >> sh));
      MODE_ROR: shift_disc = 1'b0;
      default:  shift_disc = |(d & ~({WIDTH{1'b1}} << sh));
    endcase
  endfunction

  assign out_sticky = sticky_q[LAST];
`else
  assign out_sticky = 1'b0;
`endif

  // Valid presented to each stage: the input beat, or the previous stage's valid.
  assign vin = {v_q[AMT_W-2:0], in_valid};

  // A stage may load if it or any later stage has room. This is the unrolled
  // form of en[k] = ~v[k] | en[k+1], so it has no combinational chain.
  for (genvar k = 0; k < AMT_W; k++) begin : g_en
    assign en[k] = out_ready | ~(&v_q[LAST:k]);
  end

  assign in_ready  = en[0];
  assign out_valid = v_q[LAST];
  assign out_data  = data_q[LAST];

  // Stage valid bits: a stage that is enabled takes the upstream valid,
  // otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= (v_q & ~en) | (vin & en);
    end
  end

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int unsigned SH = 2 ** k;
    logic [WIDTH-1:0] d_i;
    logic [AMT_W-1:0] a_i;
    logic [1:0]       m_i;
    logic             s_i;

    if (k == 0) begin : g_head
      assign d_i = in_data;
      assign a_i = in_amt;
      assign m_i = in_mode;
      assign s_i = in_data[WIDTH-1];
    end else begin : g_link
      assign d_i = data_q[k-1];
      assign a_i = amt_q[k-1];
      assign m_i = mode_q[k-1];
      assign s_i = sign_q[k-1];
    end

    // Payload loads only when a real beat moves in. Bubbles leave the data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
        sign_q[k] <= 1'b0;
      end else if (en[k] && vin[k]) begin
        data_q[k] <= a_i[k] ? shift_data(d_i, m_i, s_i, SH) : d_i;
        amt_q[k]  <= a_i;
        mode_q[k] <= m_i;
        sign_q[k] <= s_i;
      end
    end

`ifdef BARREL_SHIFTER_STICKY_EN
    logic st_i;

    if (k == 0) begin : g_st_head
      assign st_i = 1'b0;
    end else begin : g_st_link
      assign st_i = sticky_q[k-1];
    end

    // Sticky accumulates the bits this stage discards.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sticky_q[k] <= 1'b0;
      end else if (en[k] && vin[k]) begin
        sticky_q[k] <= st_i | (a_i[k] & shift_disc(d_i, m_i, SH));
      end
    end
`endif
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Testbench for barrel_shifter_pipe with WIDTH=8. It uses directed vectors plus
// randomized traffic. The traffic is checked against an integer-arithmetic
// reference model and an ordered queue of expected results.
module tb_barrel_shifter_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AMT_W = 3;
`ifdef BARREL_SHIFTER_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;

  barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
  } res_t;

  res_t exp_q[$];

  // Reference model: plain integer arithmetic on the operand value.
  function automatic res_t ref_shift(input logic [7:0] d, input logic [2:0] amt,
                                     input logic [1:0] mode);
    int v, a, sv, r;
    bit s;
    res_t res;
    v  = int'(d);
    a  = int'(amt);
    sv = d[7] ? v - 256 : v;
    s  = (v % (1 << a)) != 0;
    case (mode)
      2'd0:    begin r = v << a; s = (r >> 8) != 0; end
      2'd1:    r = v >> a;
      2'd2:    r = sv >>> a;
      default: begin r = (v >> a) | (v << (8 - a)); s = 1'b0; end
    endcase
    res.d = 8'(r);
    res.s = STICKY_ON & s;
    return res;
  endfunction

  // Drive one cycle of inputs at the negedge and report what happens at the next posedge.
  task automatic tick(input logic iv, input logic [7:0] id, input logic [2:0] ia,
                      input logic [1:0] im, input logic ordy,
                      output logic acc, output logic emit, output logic ov,
                      output logic [7:0] od, output logic os);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    in_amt    = ia;
    in_mode   = im;
    out_ready = ordy;
    #1;
    acc  = iv && in_ready;
    emit = out_valid && ordy;
    ov   = out_valid;
    od   = out_data;
    os   = out_sticky;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h sticky=%b, want 0 00 0",
               out_valid, out_data, out_sticky);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_directed();
    logic [1:0] tm [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [2:0] ta [8] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [7:0] td [8] = '{8'hA8, 8'h16, 8'hF6, 8'hB6, 8'hB5, 8'hB5, 8'hB5, 8'hB5};
    logic       ts [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic acc, emit, ov, os;
    logic [7:0] od;
    int n;
    for (int i = 0; i < 8; i++) begin
      acc = 1'b0; n = 0;
      while (!acc && n < 20) begin
        tick(1'b1, 8'hB5, ta[i], tm[i], 1'b1, acc, emit, ov, od, os);
        n++;
      end
      emit = 1'b0; n = 0;
      while (!emit && n < 20) begin
        tick(1'b0, 8'($urandom), 3'($urandom), 2'($urandom), 1'b1, acc, emit, ov, od, os);
        n++;
      end
      checks++;
      if (!emit) begin
        errors++;
        $display("FAIL directed_%0d: no output within bound", i);
      end else if (od !== td[i] || os !== (STICKY_ON & ts[i])) begin
        errors++;
        $display("FAIL directed_%0d mode=%0d amt=%0d: got data=%h sticky=%b, want %h %b",
                 i, tm[i], ta[i], od, os, td[i], STICKY_ON & ts[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, emit, ov, os;
    logic [7:0] od, d;
    logic [2:0] a;
    logic [1:0] m;
    int sent, got, first_acc, first_emit, last_emit, n;
    res_t e;
    sent = 0; got = 0; first_acc = -1; first_emit = -1; last_emit = -1; n = 0;
    while (got < 8 && n < 40) begin
      d = 8'($urandom); a = 3'($urandom); m = 2'($urandom);
      tick(sent < 8, d, a, m, 1'b1, acc, emit, ov, od, os);
      n++;
      if (emit) begin
        if (first_emit < 0) first_emit = int'(cyc);
        last_emit = int'(cyc);
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious: got data=%h with nothing expected", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e.d || os !== e.s) begin
            errors++;
            $display("FAIL b2b_data: got %h/%b want %h/%b", od, os, e.d, e.s);
          end
        end
      end
      if (acc) begin
        if (first_acc < 0) first_acc = int'(cyc);
        exp_q.push_back(ref_shift(d, a, m));
        sent++;
      end
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs want 8", got);
    end
    checks++;
    if (first_emit - first_acc != int'(AMT_W)) begin
      errors++;
      $display("FAIL b2b_latency: got %0d cycles want %0d", first_emit - first_acc, AMT_W);
    end
    checks++;
    if (last_emit - first_emit != 7) begin
      errors++;
      $display("FAIL b2b_rate: got span %0d cycles want 7", last_emit - first_emit);
    end
  endtask

  task automatic test_stall();
    logic acc, emit, ov, os;
    logic [7:0] od, d, held;
    logic [2:0] a;
    logic [1:0] m;
    int accepts, n, got;
    bit have_held;
    res_t e;
    accepts = 0; have_held = 1'b0; held = '0;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom); a = 3'($urandom); m = 2'($urandom);
      tick(1'b1, d, a, m, 1'b0, acc, emit, ov, od, os);
      if (ov) begin
        if (!have_held) begin
          held = od; have_held = 1'b1;
        end else begin
          checks++;
          if (od !== held) begin
            errors++;
            $display("FAIL stall_hold: got %h want %h", od, held);
          end
        end
      end
      if (acc) begin
        exp_q.push_back(ref_shift(d, a, m));
        accepts++;
      end
    end
    checks++;
    if (accepts != 3) begin
      errors++;
      $display("FAIL stall_accepts: got %0d want 3", accepts);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready: got %b want 0", in_ready);
    end
    got = 0; n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      tick(1'b0, 8'($urandom), 3'($urandom), 2'($urandom), 1'b1, acc, emit, ov, od, os);
      n++;
      if (emit) begin
        e = exp_q.pop_front();
        got++;
        checks++;
        if (od !== e.d || os !== e.s) begin
          errors++;
          $display("FAIL stall_drain: got %h/%b want %h/%b", od, os, e.d, e.s);
        end
      end
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL stall_drain_count: got %0d want 3", got);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic acc, emit, ov, os;
    logic [7:0] od;
    int spurious, n;
    res_t e;
    for (int i = 0; i < 2; i++)
      tick(1'b1, 8'($urandom), 3'($urandom), 2'($urandom), 1'b0, acc, emit, ov, od, os);
    repeat (2) tick(1'b0, 8'h00, 3'd0, 2'd0, 1'b0, acc, emit, ov, od, os);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre_valid: got %b want 1", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got out_valid=%b want 0", out_valid);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'($urandom), 3'($urandom), 2'($urandom), 1'b1, acc, emit, ov, od, os);
      if (ov) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL midreset_stale: got %0d stale valid cycles want 0", spurious);
    end
    tick(1'b1, 8'h81, 3'd1, 2'd2, 1'b1, acc, emit, ov, od, os);
    e = ref_shift(8'h81, 3'd1, 2'd2);
    emit = 1'b0; n = 0;
    while (!emit && n < 20) begin
      tick(1'b0, 8'($urandom), 3'($urandom), 2'($urandom), 1'b1, acc, emit, ov, od, os);
      n++;
    end
    checks++;
    if (!emit || od !== e.d || os !== e.s) begin
      errors++;
      $display("FAIL midreset_recover: got emit=%b %h/%b want %h/%b", emit, od, os, e.d, e.s);
    end
  endtask

  task automatic test_random();
    logic acc, emit, ov, os, iv, ordy, prev_stall;
    logic [7:0] od, d, prev_d;
    logic [2:0] a;
    logic [1:0] m;
    int sent, n;
    res_t e;
    sent = 0; n = 0; prev_stall = 1'b0; prev_d = '0;
    while ((sent < 10000 || exp_q.size() > 0) && n < 40000) begin
      iv   = (sent < 10000) && ($urandom_range(0, 9) < 8);
      ordy = (sent >= 10000) || ($urandom_range(0, 9) < 7);
      d = 8'($urandom); a = 3'($urandom); m = 2'($urandom);
      tick(iv, d, a, m, ordy, acc, emit, ov, od, os);
      n++;
      if (prev_stall) begin
        checks++;
        if (!ov || od !== prev_d) begin
          errors++;
          $display("FAIL rand_stall_hold: got valid=%b data=%h want 1 %h", ov, od, prev_d);
        end
      end
      prev_stall = ov && !ordy;
      prev_d     = od;
      if (emit) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious: got %h with nothing expected", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e.d || os !== e.s) begin
            errors++;
            $display("FAIL rand_data: got %h/%b want %h/%b", od, os, e.d, e.s);
          end
        end
      end
      if (acc) begin
        exp_q.push_back(ref_shift(d, a, m));
        sent++;
      end
    end
    checks++;
    if (sent != 10000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_complete: sent %0d pending %0d, want 10000 sent 0 pending",
               sent, exp_q.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
